// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types, default widths and arithmetic helpers for the MLP layer engine
package mlp_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, OUT} state_t;

  localparam int DEF_X_W   = 32;
  localparam int DEF_W_W   = 8;
  localparam int DEF_B_W   = 16;
  localparam int DEF_ACC_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Operands arrive sign-extended to 64 bits; the result is clamped to a signed width-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mlp_sat_mac.sv
// rtl/mlp_sat_mac.sv - one neuron's saturating accumulator with clear, enable and sticky saturation flag
module mlp_sat_mac
  import mlp_pkg::*;
#(
  parameter int IN_W  = 40,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  addend,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sat
);

  logic signed [63:0] a64;
  logic signed [63:0] p64;
  logic signed [63:0] s64;
  logic               ovf;

  assign a64 = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
  assign p64 = {{(64-IN_W){addend[IN_W-1]}}, addend};
  assign s64 = sat_add(a64, p64, ACC_W);
  assign ovf = (s64 != (a64 + p64));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= s64[ACC_W-1:0];
      if (ovf) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/mlp_dense_layer_engine.sv
// rtl/mlp_dense_layer_engine.sv - time-multiplexed dense layer: parallel neuron MACs, bias, optional ReLU, argmax
module mlp_dense_layer_engine
  import mlp_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int X_W   = DEF_X_W,
  parameter int W_W   = DEF_W_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          relu_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [X_W-1:0]         in_data,
  output logic                          w_rd_en,
  output logic [clog2(N_IN)-1:0]        w_rd_addr,
  input  logic [N_OUT*W_W-1:0]          w_rd_data,
  input  logic [N_OUT*B_W-1:0]          bias_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [N_OUT*ACC_W-1:0]        res_data,
  output logic [clog2(N_OUT)-1:0]       res_argmax,
  output logic                          res_sat,
  output logic                          busy
);

  localparam int CW  = clog2(N_IN);
  localparam int AW  = clog2(N_OUT);
  localparam int P_W = X_W + W_W;

  state_t                    state;
  logic                      relu_q;
  logic [CW-1:0]             cnt;
  logic signed [X_W-1:0]     x_s1;
  logic                      s1_v;
  logic                      clr;
  logic [N_OUT-1:0]          mac_sat;
  logic [N_OUT-1:0]          bias_sat;
  logic signed [ACC_W-1:0]   acc [N_OUT];
  logic signed [ACC_W-1:0]   r   [N_OUT];
  logic signed [ACC_W-1:0]   best;
  logic [AW-1:0]             best_idx;

  assign clr       = start && (state == IDLE);
  assign w_rd_en   = in_valid && in_ready;
  assign w_rd_addr = cnt;

  // Stage 2 multiplies the registered activation with ROM data returning this cycle.
  for (genvar k = 0; k < N_OUT; k++) begin : g_neuron
    logic signed [P_W-1:0] prod;
    logic signed [63:0]    a64;
    logic signed [63:0]    b64;
    logic signed [63:0]    s64;

    assign prod = x_s1 * $signed(w_rd_data[k*W_W +: W_W]);

    mlp_sat_mac #(.IN_W(P_W), .ACC_W(ACC_W)) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .en     (s1_v),
      .addend (prod),
      .acc    (acc[k]),
      .sat    (mac_sat[k])
    );

    assign a64         = {{(64-ACC_W){acc[k][ACC_W-1]}}, acc[k]};
    assign b64         = {{(64-B_W){bias_data[k*B_W+B_W-1]}}, bias_data[k*B_W +: B_W]};
    assign s64         = sat_add(a64, b64, ACC_W);
    assign bias_sat[k] = (s64 != (a64 + b64));
    assign r[k]        = (relu_q && (s64 < 0)) ? '0 : s64[ACC_W-1:0];
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best     = r[0];
    best_idx = '0;
    for (int k = 1; k < N_OUT; k++) begin
      if (r[k] > best) begin
        best     = r[k];
        best_idx = AW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      relu_q     <= 1'b0;
      cnt        <= '0;
      x_s1       <= '0;
      s1_v       <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_argmax <= '0;
      res_sat    <= 1'b0;
    end else begin
      s1_v <= w_rd_en;
      if (w_rd_en) x_s1 <= in_data;
      case (state)
        IDLE: begin
          if (start) begin
            relu_q   <= relu_en;
            cnt      <= '0;
            res_sat  <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_rd_en) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N_IN - 1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: state <= BIAS;
        BIAS: begin
          for (int k = 0; k < N_OUT; k++) res_data[k*ACC_W +: ACC_W] <= r[k];
          res_argmax <= best_idx;
          res_sat    <= (|mac_sat) || (|bias_sat);
          res_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_dense_layer_engine.sv
// tb/tb_mlp_dense_layer_engine.sv - scoreboard bench for the dense layer engine (N_IN=4, N_OUT=3, ACC_W=16)
module tb_mlp_dense_layer_engine;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int X_W   = 32;
  localparam int W_W   = 8;
  localparam int B_W   = 16;
  localparam int ACC_W = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic                   relu_en = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [X_W-1:0]  in_data = '0;
  logic                   w_rd_en;
  logic [1:0]             w_rd_addr;
  logic [N_OUT*W_W-1:0]   w_rd_data = '0;
  logic [N_OUT*W_W-1:0]   rom_row = '0;
  logic [N_OUT*B_W-1:0]   bias_data = '0;
  logic                   res_valid;
  logic                   res_ready = 1'b1;
  logic [N_OUT*ACC_W-1:0] res_data;
  logic [1:0]             res_argmax;
  logic                   res_sat;
  logic                   busy;

  mlp_dense_layer_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .X_W(X_W), .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .relu_en    (relu_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .w_rd_en    (w_rd_en),
    .w_rd_addr  (w_rd_addr),
    .w_rd_data  (w_rd_data),
    .bias_data  (bias_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_argmax (res_argmax),
    .res_sat    (res_sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight ROM: every row holds rom_row, returned one cycle after the read strobe.
  always @(posedge clk) w_rd_data <= w_rd_en ? rom_row : '0;

  typedef struct {
    logic signed [15:0] d0;
    logic signed [15:0] d1;
    logic signed [15:0] d2;
    int                 am;
    bit                 sat;
    int                 lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   xs[4];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int a, input int b, input int c, input int am, input bit sat, input int lat);
    exp_t e;
    e.d0 = 16'(a);
    e.d1 = 16'(b);
    e.d2 = 16'(c);
    e.am = am;
    e.sat = sat;
    e.lat = lat;
    return e;
  endfunction

  // Monitor: pops one expectation per result handshake.
  initial begin
    int   t_start;
    int   t_rise;
    bit   prev_v;
    exp_t e;
    t_start = 0;
    t_rise = 0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (start && !busy && !reset) t_start = cyc;
      if (res_valid && !prev_v) t_rise = cyc;
      prev_v = res_valid;
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("res_d0", $signed(res_data[15:0]), e.d0);
          check("res_d1", $signed(res_data[31:16]), e.d1);
          check("res_d2", $signed(res_data[47:32]), e.d2);
          check("res_argmax", res_argmax, e.am);
          check("res_sat", res_sat, e.sat);
          if (e.lat >= 0) check("latency", t_rise - t_start, e.lat);
        end
      end
    end
  end

  task automatic run_job(input bit relu, input bit [6:0] pat, input int npat);
    int idx;
    int slot;
    int guard;
    bit acc;
    @(posedge clk);
    #1;
    relu_en = relu;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idx = 0;
    slot = 0;
    guard = 0;
    while (idx < N_IN && guard < 50) begin
      in_valid = (slot < npat) ? pat[slot] : 1'b1;
      in_data = xs[idx];
      @(negedge clk);
      if (in_valid && in_ready) begin
        check("w_rd_en_on_accept", w_rd_en, 1);
        check("w_rd_addr", w_rd_addr, idx);
        acc = 1'b1;
      end else begin
        check("w_rd_en_no_accept", w_rd_en, 0);
        acc = 1'b0;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      slot++;
      guard++;
    end
    if (idx < N_IN) check("accept_timeout", idx, N_IN);
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || busy) && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (g >= 100) check("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    int g;
    xs = '{1, 2, 3, 4};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_w_rd_en", w_rd_en, 0);
    check("rst_w_rd_addr", w_rd_addr, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_argmax", res_argmax, 0);
    check("rst_res_sat", res_sat, 0);

    // ReLU job and linear job on the same data.
    rom_row = {8'sd2, 8'hFF, 8'sd1};
    bias_data = {16'hFF9C, 16'd5, 16'd0};
    sbq.push_back(mk(10, 0, 0, 0, 1'b0, 7));
    run_job(1'b1, 7'b1111, 4);
    drain();
    sbq.push_back(mk(10, -5, -80, 0, 1'b0, 7));
    run_job(1'b0, 7'b1111, 4);
    drain();

    // Saturation.
    xs = '{32767, 32767, 32767, 32767};
    rom_row = {8'sd127, 8'sd127, 8'sd127};
    bias_data = '0;
    sbq.push_back(mk(32767, 32767, 32767, 0, 1'b1, 7));
    run_job(1'b1, 7'b1111, 4);
    drain();

    // Bubbly input stream: 1,0,0,1,1,0,1.
    xs = '{1, 2, 3, 4};
    rom_row = {8'sd2, 8'hFF, 8'sd1};
    bias_data = {16'hFF9C, 16'd5, 16'd0};
    sbq.push_back(mk(10, 0, 0, 0, 1'b0, -1));
    run_job(1'b1, 7'b1011001, 7);
    drain();

    // Tie between neurons 1 and 2, held under back-pressure with stray start pulses.
    rom_row = {8'sd1, 8'sd1, 8'sd1};
    bias_data = {16'd5, 16'd5, 16'd0};
    res_ready = 1'b0;
    sbq.push_back(mk(10, 15, 15, 1, 1'b0, 7));
    run_job(1'b0, 7'b1111, 4);
    g = 0;
    while (!res_valid && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 20) check("hold_valid_timeout", res_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      start = i[0];
      @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_res_data", res_data, {16'd15, 16'd15, 16'd10});
      check("hold_res_argmax", res_argmax, 1);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    res_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    check("post_hold_busy", busy, 0);
    check("post_hold_in_ready", in_ready, 0);

    // Reset in the middle of accumulation.
    @(posedge clk);
    #1;
    relu_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 1;
    @(posedge clk);
    #1;
    in_data = 2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_result", res_valid, 0);

    rom_row = {8'sd2, 8'hFF, 8'sd1};
    bias_data = {16'hFF9C, 16'd5, 16'd0};
    sbq.push_back(mk(10, 0, 0, 0, 1'b0, 7));
    run_job(1'b1, 7'b1111, 4);
    drain();
    check("queue_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
